// File: rtl/uart_word_tx.sv
// Multi-byte 8N1 UART transmitter with selectable byte order.
// Define UART_WORD_TX_PARITY_EN to append an even parity bit per byte.
module uart_word_tx #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int WORD_BYTES = 2,
  parameter int MSB_FIRST  = 0
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst,
  input  logic                    send_en,
  input  logic [8*WORD_BYTES-1:0] data_word,
  output logic                    send_ready,
  output logic                    uart_tx_busy,
  output logic                    word_done,
  output logic                    uart_txd
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD;
  localparam int CNT_W =
    (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int IDX_W =
    (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam int WORD_W = 8 * WORD_BYTES;
  localparam logic [CNT_W-1:0] BAUD_LAST =
    CNT_W'(BAUD_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST =
    IDX_W'(WORD_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
`ifdef UART_WORD_TX_PARITY_EN
    , S_PARITY
`endif
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_baud;
  logic [2:0]         r_bit;
  logic [IDX_W-1:0]   r_idx;
  logic [WORD_W-1:0]  r_word;
  logic               r_txd;
  logic               r_busy;
  logic               r_ready;
  logic               r_done;

  logic [IDX_W-1:0]   w_sel;
  logic [7:0]         w_byte;
  logic               w_tick;
  logic               w_next_bit;

  assign w_tick = (r_baud == BAUD_LAST);
  assign w_sel  = (MSB_FIRST != 0) ?
                  (IDX_LAST - r_idx) : r_idx;

  // Byte mux written as a loop so non-power-of-2 widths stay in range
  always_comb begin
    w_byte = 8'h00;
    for (int k = 0; k < WORD_BYTES; k++) begin
      if (w_sel == IDX_W'(k)) begin
        w_byte = r_word[8*k +: 8];
      end
    end
  end

  assign w_next_bit = w_byte[r_bit + 3'd1];

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_idx   <= '0;
      r_word  <= '0;
      r_txd   <= 1'b1;
      r_busy  <= 1'b0;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (send_en) begin
            r_word  <= data_word;
            r_state <= S_START;
            r_baud  <= '0;
            r_bit   <= '0;
            r_idx   <= '0;
            r_txd   <= 1'b0;
            r_busy  <= 1'b1;
            r_ready <= 1'b0;
          end
        end
        S_START: begin
          if (w_tick) begin
            r_baud  <= '0;
            r_bit   <= '0;
            r_state <= S_DATA;
            r_txd   <= w_byte[0];
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        S_DATA: begin
          if (w_tick) begin
            r_baud <= '0;
            if (r_bit == 3'd7) begin
`ifdef UART_WORD_TX_PARITY_EN
              r_state <= S_PARITY;
              r_txd   <= ^w_byte;
`else
              r_state <= S_STOP;
              r_txd   <= 1'b1;
`endif
            end else begin
              r_bit <= r_bit + 3'd1;
              r_txd <= w_next_bit;
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
`ifdef UART_WORD_TX_PARITY_EN
        S_PARITY: begin
          if (w_tick) begin
            r_baud  <= '0;
            r_state <= S_STOP;
            r_txd   <= 1'b1;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (w_tick) begin
            r_baud <= '0;
            // Next start bit follows the stop bit with no idle gap
            if (r_idx != IDX_LAST) begin
              r_idx   <= r_idx + 1'b1;
              r_state <= S_START;
              r_txd   <= 1'b0;
            end else begin
              r_idx   <= '0;
              r_state <= S_IDLE;
              r_txd   <= 1'b1;
              r_busy  <= 1'b0;
              r_ready <= 1'b1;
              r_done  <= 1'b1;
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_baud  <= '0;
          r_bit   <= '0;
          r_idx   <= '0;
          r_txd   <= 1'b1;
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign send_ready   = r_ready;
  assign uart_tx_busy = r_busy;
  assign word_done    = r_done;
  assign uart_txd     = r_txd;

endmodule

// File: tb/tb_uart_word_tx.sv
// Scoreboard bench for uart_word_tx: two instances (2-byte LSB-first,
// 3-byte MSB-first), per-cycle line expectations queued at send time.
module tb_uart_word_tx;

  localparam int BD = 4;
`ifdef UART_WORD_TX_PARITY_EN
  localparam int F = 11;
`else
  localparam int F = 10;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        en2, en3;
  logic [15:0] d2;
  logic [23:0] d3;
  logic        rdy2, busy2, done2, txd2;
  logic        rdy3, busy3, done3, txd3;

  uart_word_tx #(
    .CLK_FREQ(400), .BAUD(100),
    .WORD_BYTES(2), .MSB_FIRST(0)
  ) u_d2 (
    .sys_clk(clk), .sys_rst(rst),
    .send_en(en2), .data_word(d2),
    .send_ready(rdy2), .uart_tx_busy(busy2),
    .word_done(done2), .uart_txd(txd2)
  );

  uart_word_tx #(
    .CLK_FREQ(400), .BAUD(100),
    .WORD_BYTES(3), .MSB_FIRST(1)
  ) u_d3 (
    .sys_clk(clk), .sys_rst(rst),
    .send_en(en3), .data_word(d3),
    .send_ready(rdy3), .uart_tx_busy(busy3),
    .word_done(done3), .uart_txd(txd3)
  );

  int   sel;
  logic o_txd, o_rdy, o_busy, o_done;

  always_comb begin
    o_txd  = txd2;
    o_rdy  = rdy2;
    o_busy = busy2;
    o_done = done2;
    if (sel == 3) begin
      o_txd  = txd3;
      o_rdy  = rdy3;
      o_busy = busy3;
      o_done = done3;
    end
  end

  bit q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic drive(input logic e, input logic [23:0] w);
    if (sel == 3) begin
      en3 = e;
      if (e) d3 = w;
    end else begin
      en2 = e;
      if (e) d2 = w[15:0];
    end
  endtask

  task automatic push_word(input logic [23:0] w);
    int         wb;
    int         s;
    logic [7:0] b;
    wb = (sel == 3) ? 3 : 2;
    for (int k = 0; k < wb; k++) begin
      s = (sel == 3) ? (wb - 1 - k) : k;
      b = w[8*s +: 8];
      repeat (BD) q.push_back(1'b0);
      for (int i = 0; i < 8; i++)
        repeat (BD) q.push_back(b[i]);
      if (F == 11)
        repeat (BD) q.push_back(^b);
      repeat (BD) q.push_back(1'b1);
    end
  endtask

  // Starts at a negedge, ends at the negedge of the word_done cycle
  task automatic send_word(input logic [23:0] w,
                           input int inject_at,
                           input int abort_at);
    int n;
    bit e;
    n = ((sel == 3) ? 3 : 2) * F * BD;
    n_cmp++;
    if (o_rdy !== 1'b1) begin
      n_err++;
      $display("FAIL ready_pre: got %b want 1", o_rdy);
    end
    push_word(w);
    drive(1'b1, w);
    @(negedge clk);
    drive(1'b0, w);
    for (int k = 0; k < n; k++) begin
      if (k == abort_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if (o_txd !== 1'b1 || o_rdy !== 1'b1 ||
            o_busy !== 1'b0 || o_done !== 1'b0) begin
          n_err++;
          $display("FAIL abort: txd/rdy/busy/done %b%b%b%b want 1100",
                   o_txd, o_rdy, o_busy, o_done);
        end
        q.delete();
        return;
      end
      e = q.pop_front();
      n_cmp++;
      if (o_txd !== e || o_busy !== 1'b1 ||
          o_rdy !== 1'b0 || o_done !== 1'b0) begin
        n_err++;
        $display("FAIL line c%0d: txd/busy/rdy/done %b%b%b%b want %b100",
                 k, o_txd, o_busy, o_rdy, o_done, e);
      end
      if (k == inject_at) drive(1'b1, 24'h00FFFF);
      else drive(1'b0, w);
      @(negedge clk);
    end
    drive(1'b0, w);
    n_cmp++;
    if (o_done !== 1'b1 || o_busy !== 1'b0 ||
        o_rdy !== 1'b1 || o_txd !== 1'b1) begin
      n_err++;
      $display("FAIL done c%0d: done/busy/rdy/txd %b%b%b%b want 1011",
               n, o_done, o_busy, o_rdy, o_txd);
    end
    n_cmp++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL sb_left: got %0d want 0", q.size());
    end
  endtask

  task automatic test_idle(input int cycles);
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      n_cmp++;
      if (o_txd !== 1'b1 || o_rdy !== 1'b1 ||
          o_busy !== 1'b0 || o_done !== 1'b0) begin
        n_err++;
        $display("FAIL idle c%0d: txd/rdy/busy/done %b%b%b%b want 1100",
                 k, o_txd, o_rdy, o_busy, o_done);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({txd2, rdy2, busy2, done2} !== 4'b1100 ||
          {txd3, rdy3, busy3, done3} !== 4'b1100) begin
        n_err++;
        $display("FAIL reset: d2 %b%b%b%b d3 %b%b%b%b want 1100",
                 txd2, rdy2, busy2, done2,
                 txd3, rdy3, busy3, done3);
      end
    end
    rst = 1'b0;
    sel = 2;
    test_idle(100);
    sel = 3;
    test_idle(2);
  endtask

  task automatic test_default_order();
    sel = 2;
    send_word(24'h00A55A, -1, -1);
    test_idle(4);
  endtask

  task automatic test_reversed_order();
    sel = 3;
    send_word(24'h123456, -1, -1);
    test_idle(4);
  endtask

  task automatic test_ignored_request();
    sel = 2;
    send_word(24'h003C96, 20, -1);
    test_idle(30);
  endtask

  task automatic test_reset_mid_byte();
    sel = 2;
    // k=13 puts the reset edge inside data bit 2 of byte 0
    send_word(24'h00BEEF, -1, 13);
    test_idle(10);
    send_word(24'h0000FF, -1, -1);
    test_idle(2);
  endtask

  task automatic test_back_to_back();
    sel = 3;
    send_word(24'hABCDEF, -1, -1);
    send_word(24'h010203, -1, -1);
    test_idle(3);
  endtask

  task automatic test_parity();
`ifdef UART_WORD_TX_PARITY_EN
    sel = 2;
    send_word(24'h000701, -1, -1);
    test_idle(2);
`endif
  endtask

  initial begin
    sel = 2;
    rst = 1'b1;
    en2 = 1'b0;
    en3 = 1'b0;
    d2  = '0;
    d3  = '0;
    @(negedge clk);
    test_reset();
    test_default_order();
    test_reversed_order();
    test_ignored_request();
    test_reset_mid_byte();
    test_back_to_back();
    test_parity();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule

// File: doc/uart_word_tx.md
# uart_word_tx

Parametrised multi-byte UART transmitter: accepts one word of `WORD_BYTES` bytes on a single-cycle valid/ready handshake, then serialises it as back-to-back 8N1 frames on `uart_txd`. Byte order is selectable. Baud generation and bit shifting are built in. It sits between any word-producing logic and the board TX pin, and replaces the fixed 16-bit, two-byte sender.

## Interface
- `CLK_FREQ`, 50_000_000: sys_clk frequency in Hz.
- `BAUD`, 115200: line rate; `BAUD_DIV = CLK_FREQ / BAUD`, truncated; must be ≥ 2.
- `WORD_BYTES`, 2: bytes per word; must be ≥ 1.
- `MSB_FIRST`, 0: 0 sends byte 0 (`data_word[7:0]`) first; 1 sends the top byte first.

Ports:
- `sys_clk` in 1: the single clock.
- `sys_rst` in 1: synchronous, active-high reset.
- `send_en` in 1: word valid.
- `data_word` in `8*WORD_BYTES`: word to send; sampled only on accept.
- `send_ready` out 1: block can accept a word.
- `uart_tx_busy` out 1: a word is in flight.
- `word_done` out 1: one-cycle pulse when the last stop bit completes.
- `uart_txd` out 1: serial line, idle high.

## Operation
- Handshake:
  - A word is accepted on a rising edge where `send_en && send_ready`.
  - `data_word` is latched whole; later input changes have no effect.
  - `send_en` while `send_ready=0` is ignored. It is not queued.
- FSM states:
  - IDLE: `send_ready=1`, `uart_tx_busy=0`, `uart_txd=1`. Accept → START, with byte index = 0.
  - START: `uart_txd=0` for `BAUD_DIV` cycles, then → DATA.
  - DATA: 8 bits, LSB first within the byte regardless of `MSB_FIRST`. Each bit lasts `BAUD_DIV` cycles. Then → PARITY if compiled in, else → STOP.
  - PARITY: one bit time (see Configuration), then → STOP.
  - STOP: `uart_txd=1` for `BAUD_DIV` cycles. At the end:
    - If byte index < `WORD_BYTES-1`: increment the index and go → START. There is no idle gap between bytes.
    - Otherwise → IDLE.
- Byte select: with `MSB_FIRST=0`, byte k is `data_word[8k+7:8k]`. With `MSB_FIRST=1`, byte k is `data_word[8(WORD_BYTES-1-k)+7 : 8(WORD_BYTES-1-k)]`.
- Counters:
  - Baud counter width is `$clog2(BAUD_DIV)`; it wraps at `BAUD_DIV-1`.
  - Bit counter is 3 bits.
  - Byte index width is `$clog2(WORD_BYTES)`, minimum 1.
- `uart_txd` is driven from a register. It never glitches between bits.

## Timing
- Reset (`sys_rst=1` at an edge), values after that edge:
  - `uart_txd=1`, `uart_tx_busy=0`, `send_ready=1`, `word_done=0`.
  - All counters are 0 and the FSM is in IDLE.
- Reset mid-frame: the frame is abandoned and the line is high after the reset edge. No `word_done` pulse is produced.
- Accept at edge T:
  - `uart_txd=0` (start bit) and `uart_tx_busy=1`, `send_ready=0`, all from edge T.
- Frame and word lengths:
  - Frame length F = 10 bit times, or 11 with parity.
  - Word length = `WORD_BYTES*F*BAUD_DIV` cycles.
- Completion:
  - The last stop bit ends at edge T + `WORD_BYTES*F*BAUD_DIV`.
  - From that edge: `word_done=1` for one cycle, `uart_tx_busy=0`, `send_ready=1`.
- Back-to-back words:
  - `send_en` held high in the `word_done` cycle is accepted at the next edge.
  - Minimum gap between words is therefore one clock of idle-high line.
- Reset has priority over a simultaneous `send_en`.

## Configuration
- `UART_WORD_TX_PARITY_EN` defined:
  - The PARITY state is inserted after the data bits.
  - The parity bit is even parity: XOR of the 8 data bits.
  - F = 11.
- Not defined:
  - PARITY state and its logic are absent.
  - F = 10, pure 8N1.

## Test plan
- Reset and idle:
  - Stimulus: hold `sys_rst` for 3 cycles, then release with `send_en=0` for 100 cycles.
  - Required: `uart_txd=1`, `send_ready=1`, `uart_tx_busy=0` throughout, and `word_done` never pulses.
- Default order:
  - Stimulus: `BAUD_DIV=4`, `WORD_BYTES=2`, `MSB_FIRST=0`, send 0xA55A.
  - Required: line shows frame 0x5A, then 0xA5. Bits are 0,0,1,0,1,1,0,1,0,1 then 0,1,0,1,0,0,1,0,1,1, each held 4 cycles. `word_done` comes exactly 80 cycles after accept.
- Reversed order:
  - Stimulus: `WORD_BYTES=3`, `MSB_FIRST=1`, send 0x123456.
  - Required: bytes 0x12, 0x34, 0x56 in that order. No idle cycles between stop and start bits. Busy lasts 120 cycles.
- Ignored request:
  - Stimulus: second `send_en` pulse with 0xFFFF asserted mid-word.
  - Required: it is ignored, the line still carries only the first word, and there is exactly one `word_done`.
- Reset mid-byte:
  - Stimulus: `sys_rst` during the third data bit of byte 0.
  - Required: `uart_txd=1` and `send_ready=1` after the reset edge, no `word_done`. A new 0x00FF then transmits correctly.
- Parity build:
  - Stimulus: with `UART_WORD_TX_PARITY_EN`, send 0x0701.
  - Required: parity bits 1 then 1, and `word_done` comes 88 cycles after accept.
